pi_bus_sequencer: RTL and testbench

- Sits between the Pi register interface and the 68K bus-cycle state machine, both clocked from the 7 MHz M68K clock (c7m).
- Captures Pi register writes and queues posted bus operations in a small FIFO.
- Splits 32-bit (long) operations into two word bus cycles.
- Drives a req/ack handshake to the bus engine and presents read results back to the Pi side.

---
 rtl/pistormx_pkg.sv | 47 ++++
 rtl/pi_bus_sequencer_op_fifo.sv | 93 +++++++++
 rtl/pi_bus_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_pi_bus_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pistormx_pkg.sv
// Shared types for the Pi-to-68K bus sequencer: Pi register selects, the
// queued operation entry, the sequencer state encoding and the strobe helper.
package pistormx_pkg;

   // Width of the 68K word address A[23:1]
   localparam int OP_AW = 23;

   // Pi register select values on pi_a
   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_ADDR_LO = 2'd1;
   localparam logic [1:0] REG_ADDR_HI = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   // One posted bus operation. dhi is the word written first in a long
   // (the older DATA value), dlo the most recent DATA value.
   typedef struct packed {
      logic [OP_AW-1:0] a;
      logic             a0;
      logic             sz;
      logic             rw;
      logic             is_long;
      logic [15:0]      dhi;
      logic [15:0]      dlo;
   } op_entry_t;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_NEXT,
      ST_WAIT2
   } seq_state_e;

   // Data strobe pair {uds_n, lds_n} for the first cycle of an entry.
   // Longs and word operations drive both strobes; a byte picks the lane
   // from address bit 0 (even byte on the upper lane).
   function automatic logic [1:0] strobe_enc(input op_entry_t e);
      logic [1:0] s;
      s = 2'b00;
      if (!e.is_long && e.sz) begin
         s = e.a0 ? 2'b10 : 2'b01;
      end
      return s;
   endfunction

endpackage

// File: rtl/pi_bus_sequencer_op_fifo.sv
// Small synchronous FIFO holding posted bus operations. The head entry stays
// in place while it is on the bus and is only removed when the bus engine
// completes it, so the read-pending flag also covers the in-flight entry.
module op_fifo
   import pistormx_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      c7m,
   input  logic      op_reqrst,
   input  logic      push_i,
   input  op_entry_t push_data_i,
   input  logic      pop_i,
   output op_entry_t head_o,
   output logic      full_o,
   output logic      empty_o,
   output logic      any_rd_o
);

   localparam int          PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

   op_entry_t        mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic [PW:0]      count_q;
   logic [PW:0]      count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o   = (count_q == DEPTH_CNT);
   assign empty_o  = (count_q == '0);
   assign head_o   = mem_q[rd_ptr_q];
   // A push into a full queue is dropped; the caller flags the overflow
   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;

   // Pointer and occupancy next-state; simultaneous push and pop keep the count
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage, per-slot valid bits and pointer registers
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            vld_q[wr_ptr_q] <= 1'b1;
         end
         if (do_pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Any valid entry (queued or on the bus) that is a read
   always_comb begin
      any_rd_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && mem_q[i].rw) begin
            any_rd_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pi_bus_sequencer.sv
// Pi register front end plus 68K bus-cycle sequencer. Pi writes build up an
// operation in staging registers; an ADDR_HI write posts it into a small
// FIFO. The sequencer drains the FIFO one operation at a time over a
// req/ack handshake, splitting longs into two word cycles.
module pi_bus_sequencer
   import pistormx_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = OP_AW
) (
   input  logic          c7m,
   input  logic          op_reqrst,
   input  logic          pi_wr_stb,
   input  logic [1:0]    pi_a,
   input  logic [15:0]   pi_d,
   output logic          txn_busy,
   output logic [15:0]   rd_data,
   output logic [15:0]   rd_data_lo,
   output logic          ovf_err,
   output logic          bus_req,
   output logic [AW-1:0] bus_a,
   output logic          bus_rw,
   output logic          bus_uds_n,
   output logic          bus_lds_n,
   output logic [15:0]   bus_dout,
   input  logic          bus_ack,
   input  logic [15:0]   bus_din
);

   // Pi-side staging. The entry register holds the address-high byte and the
   // control bits from the ADDR_HI write together with a snapshot of the
   // other staging registers, so later Pi writes cannot alter a post that is
   // still on its way into the FIFO.
   logic [15:0] d_prev_q;
   logic [15:0] d_cur_q;
   logic [14:0] a_lo_q;
   logic        a0_q;
   logic        push_q;
   op_entry_t   push_entry_q;
   logic        ovf_q;

   // FIFO interface
   op_entry_t   head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_any_rd;
   logic        pop;

   // Sequencer and bus-side registers
   seq_state_e  state_q;
   seq_state_e  state_d;
   logic        bus_req_q;
   logic        bus_req_d;
   logic [AW-1:0] bus_a_q;
   logic [AW-1:0] bus_a_d;
   logic        bus_rw_q;
   logic        bus_rw_d;
   logic        uds_n_q;
   logic        uds_n_d;
   logic        lds_n_q;
   logic        lds_n_d;
   logic [15:0] bus_dout_q;
   logic [15:0] bus_dout_d;
   logic [15:0] rd_data_q;
   logic [15:0] rd_data_d;
   logic [15:0] rd_lo_q;
   logic [15:0] rd_lo_d;
   logic [1:0]  strobes;
   logic        ack_ok;

   // Decode Pi register writes into the staging registers and post on ADDR_HI
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         d_prev_q     <= '0;
         d_cur_q      <= '0;
         a_lo_q       <= '0;
         a0_q         <= 1'b0;
         push_q       <= 1'b0;
         push_entry_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (pi_wr_stb) begin
            case (pi_a)
               REG_DATA: begin
                  d_prev_q <= d_cur_q;
                  d_cur_q  <= pi_d;
               end
               REG_ADDR_LO: begin
                  a_lo_q <= pi_d[15:1];
                  a0_q   <= pi_d[0];
               end
               REG_ADDR_HI: begin
                  push_q       <= 1'b1;
                  push_entry_q <= '{a:       {pi_d[7:0], a_lo_q},
                                    a0:      a0_q,
                                    sz:      pi_d[8],
                                    rw:      pi_d[9],
                                    is_long: pi_d[10],
                                    dhi:     d_prev_q,
                                    dlo:     d_cur_q};
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Sticky overflow flag: a dropped post sets it, a STATUS write with bit 0 clears it
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         ovf_q <= 1'b0;
      end else if (push_q && fifo_full) begin
         ovf_q <= 1'b1;
      end else if (pi_wr_stb && (pi_a == REG_STATUS) && pi_d[0]) begin
         ovf_q <= 1'b0;
      end
   end

   op_fifo #(
      .DEPTH(DEPTH)
   ) u_op_fifo (
      .c7m        (c7m),
      .op_reqrst  (op_reqrst),
      .push_i     (push_q),
      .push_data_i(push_entry_q),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .any_rd_o   (fifo_any_rd)
   );

   assign strobes = strobe_enc(head);
   // An ack only counts while a request is actually outstanding
   assign ack_ok  = bus_ack && bus_req_q;

   // Sequencer next-state and bus-side register updates
   always_comb begin
      state_d    = state_q;
      bus_req_d  = bus_req_q;
      bus_a_d    = bus_a_q;
      bus_rw_d   = bus_rw_q;
      uds_n_d    = uds_n_q;
      lds_n_d    = lds_n_q;
      bus_dout_d = bus_dout_q;
      rd_data_d  = rd_data_q;
      rd_lo_d    = rd_lo_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus_a_d    = AW'(head.a);
            bus_rw_d   = head.rw;
            uds_n_d    = strobes[1];
            lds_n_d    = strobes[0];
            bus_dout_d = head.is_long ? head.dhi : head.dlo;
            bus_req_d  = 1'b1;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (ack_ok) begin
               bus_req_d = 1'b0;
               if (head.rw) begin
                  rd_data_d = bus_din;
               end
               if (head.is_long) begin
                  state_d = ST_NEXT;
               end else begin
                  pop     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_NEXT: begin
            bus_a_d    = bus_a_q + AW'(1);
            bus_dout_d = head.dlo;
            bus_req_d  = 1'b1;
            state_d    = ST_WAIT2;
         end
         ST_WAIT2: begin
            if (ack_ok) begin
               bus_req_d = 1'b0;
               if (head.rw) begin
                  rd_lo_d = bus_din;
               end
               pop     = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and bus-side registers; reset abandons any cycle in flight
   always_ff @(posedge c7m or posedge op_reqrst) begin
      if (op_reqrst) begin
         state_q    <= ST_IDLE;
         bus_req_q  <= 1'b0;
         bus_a_q    <= '0;
         bus_rw_q   <= 1'b1;
         uds_n_q    <= 1'b1;
         lds_n_q    <= 1'b1;
         bus_dout_q <= '0;
         rd_data_q  <= '0;
         rd_lo_q    <= '0;
      end else begin
         state_q    <= state_d;
         bus_req_q  <= bus_req_d;
         bus_a_q    <= bus_a_d;
         bus_rw_q   <= bus_rw_d;
         uds_n_q    <= uds_n_d;
         lds_n_q    <= lds_n_d;
         bus_dout_q <= bus_dout_d;
         rd_data_q  <= rd_data_d;
         rd_lo_q    <= rd_lo_d;
      end
   end

   // Busy whenever the queue cannot take a post or a read is anywhere in the pipe
   assign txn_busy   = fifo_full || fifo_any_rd || (push_q && push_entry_q.rw);

   assign rd_data    = rd_data_q;
   assign rd_data_lo = rd_lo_q;
   assign ovf_err    = ovf_q;
   assign bus_req    = bus_req_q;
   assign bus_a      = bus_a_q;
   assign bus_rw     = bus_rw_q;
   assign bus_uds_n  = uds_n_q;
   assign bus_lds_n  = lds_n_q;
   assign bus_dout   = bus_dout_q;

endmodule

// File: tb/tb_pi_bus_sequencer.sv
// Testbench for pi_bus_sequencer: directed Pi register writes, a hand-driven
// bus engine, and a scoreboard of expected bus cycles checked by a monitor.
module tb_pi_bus_sequencer;
   import pistormx_pkg::*;

   logic        c7m = 1'b0;
   logic        op_reqrst;
   logic        pi_wr_stb;
   logic [1:0]  pi_a;
   logic [15:0] pi_d;
   logic        txn_busy;
   logic [15:0] rd_data;
   logic [15:0] rd_data_lo;
   logic        ovf_err;
   logic        bus_req;
   logic [22:0] bus_a;
   logic        bus_rw;
   logic        bus_uds_n;
   logic        bus_lds_n;
   logic [15:0] bus_dout;
   logic        bus_ack;
   logic [15:0] bus_din;

   typedef struct packed {
      logic [22:0] a;
      logic        rw;
      logic        uds_n;
      logic        lds_n;
      logic [15:0] dout;
   } cyc_t;

   cyc_t expQ[$];
   cyc_t monExp;
   int   checks   = 0;
   int   errors   = 0;
   int   reqCount = 0;
   int   r0;
   logic prevReq  = 1'b0;

   pi_bus_sequencer #(.DEPTH(2), .AW(23)) dut (
      .c7m       (c7m),
      .op_reqrst (op_reqrst),
      .pi_wr_stb (pi_wr_stb),
      .pi_a      (pi_a),
      .pi_d      (pi_d),
      .txn_busy  (txn_busy),
      .rd_data   (rd_data),
      .rd_data_lo(rd_data_lo),
      .ovf_err   (ovf_err),
      .bus_req   (bus_req),
      .bus_a     (bus_a),
      .bus_rw    (bus_rw),
      .bus_uds_n (bus_uds_n),
      .bus_lds_n (bus_lds_n),
      .bus_dout  (bus_dout),
      .bus_ack   (bus_ack),
      .bus_din   (bus_din)
   );

   // 7 MHz-style free-running clock
   always #5 c7m = ~c7m;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One Pi register write: strobe high for exactly one rising edge
   task automatic applyStimulus(input logic [1:0] a, input logic [15:0] d);
      @(negedge c7m);
      pi_wr_stb = 1'b1;
      pi_a      = a;
      pi_d      = d;
      @(negedge c7m);
      pi_wr_stb = 1'b0;
   endtask

   // Bus engine: wait (bounded) for a request, then return a one-cycle ack
   task automatic doAck(input logic [15:0] din);
      int n;
      n = 0;
      while (!bus_req && n < 50) begin
         @(negedge c7m);
         n++;
      end
      if (!bus_req) begin
         checks++;
         errors++;
         $display("[TB] FAIL ack_timeout: got bus_req=0 after %0d cycles, expected 1", n);
      end else begin
         bus_ack = 1'b1;
         bus_din = din;
         @(negedge c7m);
         bus_ack = 1'b0;
         bus_din = 16'h0000;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req"},   {31'd0, bus_req},   32'd0);
      checkOutput({tag, "_rw"},    {31'd0, bus_rw},    32'd1);
      checkOutput({tag, "_uds"},   {31'd0, bus_uds_n}, 32'd1);
      checkOutput({tag, "_lds"},   {31'd0, bus_lds_n}, 32'd1);
      checkOutput({tag, "_a"},     {9'd0, bus_a},      32'd0);
      checkOutput({tag, "_dout"},  {16'd0, bus_dout},  32'd0);
      checkOutput({tag, "_rd"},    {16'd0, rd_data},   32'd0);
      checkOutput({tag, "_rdlo"},  {16'd0, rd_data_lo}, 32'd0);
      checkOutput({tag, "_ovf"},   {31'd0, ovf_err},   32'd0);
      checkOutput({tag, "_busy"},  {31'd0, txn_busy},  32'd0);
   endtask

   // Monitor: every new bus request is matched against the next expected cycle
   always @(negedge c7m) begin
      if (bus_req && !prevReq) begin
         reqCount++;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_req: got cycle at bus_a=%h, expected none", bus_a);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("cyc_a",    {9'd0, bus_a},      {9'd0, monExp.a});
            checkOutput("cyc_rw",   {31'd0, bus_rw},    {31'd0, monExp.rw});
            checkOutput("cyc_uds",  {31'd0, bus_uds_n}, {31'd0, monExp.uds_n});
            checkOutput("cyc_lds",  {31'd0, bus_lds_n}, {31'd0, monExp.lds_n});
            checkOutput("cyc_dout", {16'd0, bus_dout},  {16'd0, monExp.dout});
         end
      end
      prevReq = bus_req;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      op_reqrst = 1'b1;
      pi_wr_stb = 1'b0;
      pi_a      = 2'd0;
      pi_d      = 16'h0000;
      bus_ack   = 1'b0;
      bus_din   = 16'h0000;
      repeat (3) @(negedge c7m);
      checkResetValues("rst0");
      op_reqrst = 1'b0;
      @(negedge c7m);

      // Word write with exact request latency
      applyStimulus(REG_DATA,    16'hBEEF);
      applyStimulus(REG_ADDR_LO, 16'h1234);
      expQ.push_back('{a: 23'h00091A, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'hBEEF});
      applyStimulus(REG_ADDR_HI, 16'h0000);
      checkOutput("wr_lat_n",  {31'd0, bus_req}, 32'd0);
      @(negedge c7m);
      checkOutput("wr_lat_n1", {31'd0, bus_req}, 32'd0);
      @(negedge c7m);
      checkOutput("wr_lat_n2", {31'd0, bus_req}, 32'd0);
      @(negedge c7m);
      checkOutput("wr_lat_n3", {31'd0, bus_req}, 32'd1);
      checkOutput("wr_busy",   {31'd0, txn_busy}, 32'd0);
      doAck(16'h0000);
      checkOutput("wr_req_drop", {31'd0, bus_req}, 32'd0);
      checkOutput("wr_busy_after", {31'd0, txn_busy}, 32'd0);

      // Byte read at an odd address (sz=1, rw=1, a_hi=0x01)
      applyStimulus(REG_ADDR_LO, 16'h0001);
      expQ.push_back('{a: 23'h008000, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b0, dout: 16'hBEEF});
      applyStimulus(REG_ADDR_HI, 16'h0301);
      repeat (3) @(negedge c7m);
      checkOutput("brd_busy", {31'd0, txn_busy}, 32'd1);
      doAck(16'h00A5);
      checkOutput("brd_data", {16'd0, rd_data}, 32'h0000_00A5);
      checkOutput("brd_busy_after", {31'd0, txn_busy}, 32'd0);

      // Long write wrapping from the top of the address space
      r0 = reqCount;
      applyStimulus(REG_DATA,    16'h1111);
      applyStimulus(REG_DATA,    16'h2222);
      applyStimulus(REG_ADDR_LO, 16'hFFFE);
      expQ.push_back('{a: 23'h7FFFFF, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h1111});
      expQ.push_back('{a: 23'h000000, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h2222});
      applyStimulus(REG_ADDR_HI, 16'h04FF);
      doAck(16'h0000);
      doAck(16'h0000);
      repeat (6) @(negedge c7m);
      checkOutput("lw_pulses", reqCount - r0, 32'd2);

      // Long read: high word into rd_data, low word into rd_data_lo
      applyStimulus(REG_ADDR_LO, 16'h0010);
      expQ.push_back('{a: 23'h000008, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h1111});
      expQ.push_back('{a: 23'h000009, rw: 1'b1, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h2222});
      applyStimulus(REG_ADDR_HI, 16'h0600);
      doAck(16'hCAFE);
      doAck(16'hF00D);
      checkOutput("lrd_hi",   {16'd0, rd_data},    32'h0000_CAFE);
      checkOutput("lrd_lo",   {16'd0, rd_data_lo}, 32'h0000_F00D);
      checkOutput("lrd_busy", {31'd0, txn_busy},   32'd0);

      // Overflow: three posted writes with no ack, only two survive
      applyStimulus(REG_DATA,    16'h3333);
      applyStimulus(REG_ADDR_LO, 16'h0200);
      r0 = reqCount;
      expQ.push_back('{a: 23'h000100, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h3333});
      expQ.push_back('{a: 23'h000100, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h3333});
      applyStimulus(REG_ADDR_HI, 16'h0000);
      @(negedge c7m);
      checkOutput("ovf_busy1", {31'd0, txn_busy}, 32'd0);
      applyStimulus(REG_ADDR_HI, 16'h0000);
      @(negedge c7m);
      checkOutput("ovf_busy2", {31'd0, txn_busy}, 32'd1);
      checkOutput("ovf_flag2", {31'd0, ovf_err},  32'd0);
      applyStimulus(REG_ADDR_HI, 16'h0000);
      @(negedge c7m);
      checkOutput("ovf_flag3", {31'd0, ovf_err},  32'd1);
      doAck(16'h0000);
      doAck(16'h0000);
      repeat (8) @(negedge c7m);
      checkOutput("ovf_pulses", reqCount - r0, 32'd2);
      checkOutput("ovf_busy_end", {31'd0, txn_busy}, 32'd0);
      checkOutput("ovf_sticky",   {31'd0, ovf_err},  32'd1);
      applyStimulus(REG_STATUS, 16'h0001);
      @(negedge c7m);
      checkOutput("ovf_clear", {31'd0, ovf_err}, 32'd0);

      // Spurious ack while idle changes nothing
      r0 = reqCount;
      @(negedge c7m);
      bus_ack = 1'b1;
      bus_din = 16'hFFFF;
      @(negedge c7m);
      bus_ack = 1'b0;
      bus_din = 16'h0000;
      repeat (5) @(negedge c7m);
      checkOutput("spur_req",  {31'd0, bus_req},  32'd0);
      checkOutput("spur_cnt",  reqCount - r0,     32'd0);
      checkOutput("spur_rd",   {16'd0, rd_data},  32'h0000_CAFE);
      checkOutput("spur_busy", {31'd0, txn_busy}, 32'd0);
      expQ.push_back('{a: 23'h000100, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h3333});
      applyStimulus(REG_ADDR_HI, 16'h0000);
      doAck(16'h0000);
      repeat (6) @(negedge c7m);
      checkOutput("spur_fifo", reqCount - r0, 32'd1);

      // Reset in the middle of a cycle with one more entry queued
      applyStimulus(REG_ADDR_LO, 16'h0400);
      expQ.push_back('{a: 23'h000200, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0, dout: 16'h3333});
      applyStimulus(REG_ADDR_HI, 16'h0000);
      repeat (3) @(negedge c7m);
      checkOutput("mid_req_up", {31'd0, bus_req}, 32'd1);
      applyStimulus(REG_ADDR_HI, 16'h0000);
      repeat (2) @(negedge c7m);
      r0 = reqCount;
      op_reqrst = 1'b1;
      #1;
      checkOutput("mid_async_req", {31'd0, bus_req}, 32'd0);
      @(negedge c7m);
      checkResetValues("mid");
      op_reqrst = 1'b0;
      repeat (10) @(negedge c7m);
      checkOutput("mid_no_retry", reqCount - r0, 32'd0);
      checkOutput("mid_req_low",  {31'd0, bus_req},  32'd0);
      checkOutput("mid_busy",     {31'd0, txn_busy}, 32'd0);

      checkOutput("exp_drained", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
